// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation encodings
// and a helper that identifies the shift/rotate operations.
package usr_pkg;

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHL  = 3'b001;
   localparam logic [2:0] MODE_SHR  = 3'b010;
   localparam logic [2:0] MODE_ROL  = 3'b011;
   localparam logic [2:0] MODE_ROR  = 3'b100;
   localparam logic [2:0] MODE_LOAD = 3'b101;
   localparam logic [2:0] MODE_CLR  = 3'b110;

   function automatic logic is_shift(input logic [2:0] mode);
      return (mode == MODE_SHL) || (mode == MODE_SHR) ||
             (mode == MODE_ROL) || (mode == MODE_ROR);
   endfunction

endpackage

// File: rtl/universal_shift_reg_shift_bit_counter.sv
// Counts shifts within a word, wrapping after WIDTH shifts and emitting a
// registered one-cycle word_done pulse in the cycle following the wrap.
module shift_bit_counter #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             done
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         done <= 1'b0;
      end else if (clr) begin
         cnt  <= '0;
         done <= 1'b0;
      end else if (inc) begin
         if (cnt == CNT_W'(WIDTH - 1)) begin
            cnt  <= '0;
            done <= 1'b1;
         end else begin
            cnt  <= cnt + CNT_W'(1);
            done <= 1'b0;
         end
      end else begin
         done <= 1'b0;
      end
   end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit register with per-cycle hold/shift/rotate/load/clear and a
// word-boundary tracker for serialiser/deserialiser use.
module universal_shift_reg
   import usr_pkg::*;
#(
   parameter  int               WIDTH     = 8,
   parameter  logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int               CNT_W     = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             sin,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic [CNT_W-1:0] shift_cnt,
   output logic             word_done
);

   logic cnt_inc;
   logic cnt_clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q    <= RESET_VAL;
         sout <= 1'b0;
      end else if (en) begin
         case (mode)
            MODE_SHL: begin
               q    <= {q[WIDTH-2:0], sin};
               sout <= q[WIDTH-1];
            end
            MODE_SHR: begin
               q    <= {sin, q[WIDTH-1:1]};
               sout <= q[0];
            end
            MODE_ROL: begin
               q    <= {q[WIDTH-2:0], q[WIDTH-1]};
               sout <= q[WIDTH-1];
            end
            MODE_ROR: begin
               q    <= {q[0], q[WIDTH-1:1]};
               sout <= q[0];
            end
            MODE_LOAD: begin
               q    <= d;
               sout <= 1'b0;
            end
            MODE_CLR: begin
               q    <= '0;
               sout <= 1'b0;
            end
            default: ;  // hold and the reserved encoding keep q and sout
         endcase
      end
   end

   // LOAD/CLEAR restart the word; en=0 freezes the count and suppresses the pulse
   assign cnt_inc = en && is_shift(mode);
   assign cnt_clr = en && ((mode == MODE_LOAD) || (mode == MODE_CLR));

   shift_bit_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cnt_inc),
      .clr   (cnt_clr),
      .cnt   (shift_cnt),
      .done  (word_done)
   );

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg: an 8-bit instance against a
// behavioural model, plus WIDTH=2 and WIDTH=16 instances for the word pulse.
module tb_universal_shift_reg;
   import usr_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // 8-bit instance
   logic       en, sin;
   logic [2:0] mode;
   logic [7:0] d, q;
   logic       sout, word_done;
   logic [3:0] shift_cnt;

   // WIDTH=2 instance
   logic       en2, sin2;
   logic [2:0] mode2;
   logic [1:0] d2, q2;
   logic       sout2, done2;
   logic [1:0] cnt2;

   // WIDTH=16 instance with all-ones reset value
   logic        en16, sin16;
   logic [2:0]  mode16;
   logic [15:0] d16, q16;
   logic        sout16, done16;
   logic [4:0]  cnt16;

   universal_shift_reg #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sin(sin), .d(d),
      .q(q), .sout(sout), .shift_cnt(shift_cnt), .word_done(word_done));

   universal_shift_reg #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2), .sin(sin2), .d(d2),
      .q(q2), .sout(sout2), .shift_cnt(cnt2), .word_done(done2));

   universal_shift_reg #(.WIDTH(16), .RESET_VAL(16'hFFFF)) dut16 (
      .clk(clk), .rst_n(rst_n), .en(en16), .mode(mode16), .sin(sin16), .d(d16),
      .q(q16), .sout(sout16), .shift_cnt(cnt16), .word_done(done16));

   typedef struct {
      logic [7:0] q;
      logic       sout;
      logic [3:0] cnt;
      logic       done;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   logic [7:0] m_q;
   logic       m_sout;
   logic [3:0] m_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   // Drive one operation, predict the result, then compare after the edge
   task automatic step(input logic e, input logic [2:0] m, input logic s, input logic [7:0] dd);
      exp_t x;
      logic shifted;
      en = e; mode = m; sin = s; d = dd;
      shifted = 1'b0;
      x.done  = 1'b0;
      if (e) begin
         case (m)
            3'b001: begin m_sout = m_q[7]; m_q = {m_q[6:0], s};    shifted = 1'b1; end
            3'b010: begin m_sout = m_q[0]; m_q = {s, m_q[7:1]};    shifted = 1'b1; end
            3'b011: begin m_sout = m_q[7]; m_q = {m_q[6:0], m_q[7]}; shifted = 1'b1; end
            3'b100: begin m_sout = m_q[0]; m_q = {m_q[0], m_q[7:1]}; shifted = 1'b1; end
            3'b101: begin m_q = dd;    m_sout = 1'b0; m_cnt = 4'd0; end
            3'b110: begin m_q = 8'h00; m_sout = 1'b0; m_cnt = 4'd0; end
            default: ;
         endcase
         if (shifted) begin
            if (m_cnt == 4'd7) begin
               m_cnt  = 4'd0;
               x.done = 1'b1;
            end else begin
               m_cnt = m_cnt + 4'd1;
            end
         end
      end
      x.q = m_q; x.sout = m_sout; x.cnt = m_cnt;
      sb.push_back(x);
      @(posedge clk); #1;
      x = sb.pop_front();
      chk("q",         32'(q),         32'(x.q));
      chk("sout",      32'(sout),      32'(x.sout));
      chk("shift_cnt", 32'(shift_cnt), 32'(x.cnt));
      chk("word_done", 32'(word_done), 32'(x.done));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] pat;
      int         pulses;
      rst_n = 1'b0;
      en = 1'b0; mode = MODE_HOLD; sin = 1'b0; d = '0;
      en2 = 1'b0; mode2 = MODE_HOLD; sin2 = 1'b0; d2 = '0;
      en16 = 1'b0; mode16 = MODE_HOLD; sin16 = 1'b0; d16 = '0;
      m_q = 8'h00; m_sout = 1'b0; m_cnt = 4'd0;

      // Reset state of all instances, including the non-zero RESET_VAL
      @(posedge clk); #1;
      chk("rst_q",     32'(q), 32'h00);
      chk("rst_sout",  32'(sout), 32'h0);
      chk("rst_cnt",   32'(shift_cnt), 32'h0);
      chk("rst_done",  32'(word_done), 32'h0);
      chk("rst_q16",   32'(q16), 32'hFFFF);
      chk("rst_cnt16", 32'(cnt16), 32'h0);
      #3 rst_n = 1'b1;

      // Asynchronous reset mid-cycle, mid-word, with sout=1
      step(1'b1, MODE_LOAD, 1'b0, 8'h3C);
      step(1'b1, MODE_LOAD, 1'b0, 8'hC3);
      step(1'b1, MODE_SHL,  1'b0, 8'h00);
      step(1'b1, MODE_ROL,  1'b0, 8'h00);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_q",    32'(q), 32'h00);
      chk("arst_sout", 32'(sout), 32'h0);
      chk("arst_cnt",  32'(shift_cnt), 32'h0);
      #1 rst_n = 1'b1;
      m_q = 8'h00; m_sout = 1'b0; m_cnt = 4'd0;

      // Serialise 0xA5 MSB first
      step(1'b1, MODE_LOAD, 1'b0, 8'hA5);
      pat = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, MODE_SHL, 1'b0, 8'h00);
         chk("ser_bit", 32'(sout), 32'(pat[7-i]));
      end
      chk("ser_q_end",    32'(q), 32'h00);
      chk("ser_done_end", 32'(word_done), 32'h1);
      step(1'b1, MODE_HOLD, 1'b0, 8'h00);

      // Rotate both ways
      step(1'b1, MODE_LOAD, 1'b0, 8'h81);
      step(1'b1, MODE_ROR,  1'b0, 8'h00);
      chk("ror_q", 32'(q), 32'hC0);
      step(1'b1, MODE_ROL,  1'b0, 8'h00);
      chk("rol_q", 32'(q), 32'h81);

      // Enable low holds everything; reserved mode holds
      step(1'b1, MODE_LOAD, 1'b0, 8'h5A);
      for (int i = 0; i < 5; i++) step(1'b0, MODE_SHL, 1'b1, 8'hFF);
      step(1'b1, 3'b111, 1'b1, 8'hFF);
      chk("rsv_q", 32'(q), 32'h5A);

      // Restart mid-word: partial count discarded by LOAD
      step(1'b1, MODE_CLR, 1'b0, 8'h00);
      for (int i = 0; i < 5; i++) step(1'b1, MODE_SHR, 1'b1, 8'h00);
      chk("shr_q",   32'(q), 32'hF8);
      chk("shr_cnt", 32'(shift_cnt), 32'd5);
      step(1'b1, MODE_LOAD, 1'b0, 8'h0F);
      pulses = 0;
      for (int i = 0; i < 9; i++) begin
         step(1'b1, (i % 2 == 0) ? MODE_SHL : MODE_ROR, 1'(i % 2), 8'h00);
         if (word_done) pulses++;
      end
      chk("restart_pulses", 32'(pulses), 32'd1);

      // WIDTH=2: pulse every 2 shifts
      for (int i = 0; i < 6; i++) begin
         en2 = 1'b1; mode2 = MODE_SHL; sin2 = 1'(i);
         @(posedge clk); #1;
         chk("w2_done", 32'(done2), 32'((i % 2) == 1));
      end
      en2 = 1'b0;

      // WIDTH=16: pulse every 16 shifts, back-to-back
      for (int i = 0; i < 32; i++) begin
         en16 = 1'b1; mode16 = MODE_SHL; sin16 = 1'b0;
         @(posedge clk); #1;
         chk("w16_done", 32'(done16), 32'((i % 16) == 15));
         if (i == 15) chk("w16_q", 32'(q16), 32'h0000);
      end
      en16 = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
